// File: rtl/VX_om_pkg.sv
// Shared OM memory-channel types, constants and the byte-merge helper used by
// the responder's SRAM write path.
package VX_om_pkg;

    localparam int OM_OOB_CNT_BITS = 16;
    localparam int OM_ADDR_WIDTH   = 32;
    localparam int OM_TAG_WIDTH    = 8;

    typedef struct packed {
        logic                     rw;
        logic [OM_ADDR_WIDTH-1:0] addr;
        logic [3:0]               byteen;
        logic [31:0]              data;
        logic [OM_TAG_WIDTH-1:0]  tag;
    } om_mem_req_t;

    typedef struct packed {
        logic [31:0]             data;
        logic [OM_TAG_WIDTH-1:0] tag;
    } om_mem_rsp_t;

    function automatic logic [31:0] om_byte_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  byteen
    );
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (byteen[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/vx_om_rsp_queue.sv
// Response FIFO with a registered head entry; push and pop may coincide in any
// state, so a full queue can accept a new entry in the cycle it drains one.
module vx_om_rsp_queue
    import VX_om_pkg::*;
#(
    parameter int DATAW = 40,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [DATAW-1:0] push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [DATAW-1:0] data_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

    logic [DATAW-1:0] store_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DATAW-1:0] head_q, head_d;
    logic             valid_q;
    logic             pop_s, push_s;
    logic [CW-1:0]    remain_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    // Pointer/count bookkeeping and selection of the next head entry.
    always_comb begin
        pop_s    = pop_i && (cnt_q != {CW{1'b0}});
        push_s   = push_i && ((cnt_q != DEPTH_C) || pop_s);
        remain_s = cnt_q - CW'(pop_s);
        cnt_d    = remain_s + CW'(push_s);
        rd_ptr_d = pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        head_d   = head_q;
        // The head is refilled from storage if anything older survives the pop,
        // otherwise it bypasses straight from the incoming push.
        if (remain_s != {CW{1'b0}}) begin
            head_d = store_q[rd_ptr_d];
        end else if (push_s) begin
            head_d = push_data_i;
        end else begin
            head_d = head_q;
        end
    end

    // Control state and head register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            cnt_q    <= {CW{1'b0}};
            head_q   <= {DATAW{1'b0}};
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            head_q   <= head_d;
            valid_q  <= (cnt_d != {CW{1'b0}});
        end
    end

    // Entry storage, deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            store_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = head_q;

endmodule

// File: rtl/vx_om_mem_responder.sv
// Responder end of the OM cache-channel memory protocol: local SRAM, fixed
// latency read pipe, credit-limited reads and an in-order response queue.
module vx_om_mem_responder
    import VX_om_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    TAG_WIDTH      = 8,
    parameter int                    MEM_WORDS      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                    LATENCY        = 2,
    parameter int                    RSP_QUEUE_SIZE = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       req_valid,
    input  logic                       req_rw,
    input  logic [ADDR_WIDTH-1:0]      req_addr,
    input  logic [3:0]                 req_byteen,
    input  logic [31:0]                req_data,
    input  logic [TAG_WIDTH-1:0]       req_tag,
    output logic                       req_ready,
    output logic                       rsp_valid,
    output logic [31:0]                rsp_data,
    output logic [TAG_WIDTH-1:0]       rsp_tag,
    input  logic                       rsp_ready,
    output logic [OM_OOB_CNT_BITS-1:0] oob_count
);

    localparam int IW  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int CRW = $clog2(RSP_QUEUE_SIZE + 1);
    localparam int QW  = 32 + TAG_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] MEM_WORDS_C = ADDR_WIDTH'(MEM_WORDS);
    localparam logic [CRW-1:0]        CREDITS_RST = CRW'(RSP_QUEUE_SIZE);

    logic [31:0]                mem_q [MEM_WORDS];
    logic [CRW-1:0]             credits_q, credits_d;
    logic [OM_OOB_CNT_BITS-1:0] oob_q, oob_d;

    logic [ADDR_WIDTH-1:0] idx_s;
    logic [IW-1:0]         mem_idx_s;
    logic                  in_range_s;
    logic                  credit_ok_s;
    logic                  rd_fire_s, wr_fire_s, rsp_fire_s;
    logic [31:0]           rd_data_s;
    logic                  push_valid_s;
    logic [31:0]           push_data_s;
    logic [TAG_WIDTH-1:0]  push_tag_s;
    logic                  q_valid_s;
    logic [QW-1:0]         q_data_s;

    // Address decode and handshake qualification. Addresses below the base wrap
    // to huge indices and therefore fall out of range.
    always_comb begin
        idx_s       = req_addr - BASE_ADDR;
        mem_idx_s   = idx_s[IW-1:0];
        in_range_s  = (idx_s < MEM_WORDS_C);
        credit_ok_s = (credits_q != {CRW{1'b0}});
        rd_fire_s   = req_valid && !req_rw && credit_ok_s;
        wr_fire_s   = req_valid && req_rw;
        rsp_fire_s  = q_valid_s && rsp_ready;
        rd_data_s   = in_range_s ? mem_q[mem_idx_s] : 32'h0000_0000;
    end

    assign req_ready = req_rw ? 1'b1 : credit_ok_s;

    // Credit and out-of-range counter next state.
    always_comb begin
        credits_d = credits_q - CRW'(rd_fire_s) + CRW'(rsp_fire_s);
        if ((rd_fire_s || wr_fire_s) && !in_range_s && (oob_q != {OM_OOB_CNT_BITS{1'b1}})) begin
            oob_d = oob_q + OM_OOB_CNT_BITS'(1);
        end else begin
            oob_d = oob_q;
        end
    end

    // Credit pool and saturating out-of-range counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            credits_q <= CREDITS_RST;
            oob_q     <= {OM_OOB_CNT_BITS{1'b0}};
        end else begin
            credits_q <= credits_d;
            oob_q     <= oob_d;
        end
    end

    // SRAM byte-enabled write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_fire_s && in_range_s) begin
            mem_q[mem_idx_s] <= om_byte_merge(mem_q[mem_idx_s], req_data, req_byteen);
        end
    end

    // The queue's head register is the final latency stage, so the pipe itself
    // holds LATENCY-1 registers (none when LATENCY is 1).
    generate
        if (LATENCY == 1) begin : g_direct
            assign push_valid_s = rd_fire_s;
            assign push_data_s  = rd_data_s;
            assign push_tag_s   = req_tag;
        end else begin : g_pipe
            logic [LATENCY-2:0]   vld_q;
            logic [31:0]          data_q [LATENCY-1];
            logic [TAG_WIDTH-1:0] tag_q  [LATENCY-1];

            // Read pipeline: valid, data and tag shift together, never stall.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    vld_q <= '0;
                    for (int i = 0; i < LATENCY - 1; i++) begin
                        data_q[i] <= 32'h0000_0000;
                        tag_q[i]  <= {TAG_WIDTH{1'b0}};
                    end
                end else begin
                    vld_q[0]  <= rd_fire_s;
                    data_q[0] <= rd_data_s;
                    tag_q[0]  <= req_tag;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        vld_q[i]  <= vld_q[i-1];
                        data_q[i] <= data_q[i-1];
                        tag_q[i]  <= tag_q[i-1];
                    end
                end
            end

            assign push_valid_s = vld_q[LATENCY-2];
            assign push_data_s  = data_q[LATENCY-2];
            assign push_tag_s   = tag_q[LATENCY-2];
        end
    endgenerate

    vx_om_rsp_queue #(
        .DATAW (QW),
        .DEPTH (RSP_QUEUE_SIZE)
    ) u_rsp_queue (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (push_valid_s),
        .push_data_i ({push_data_s, push_tag_s}),
        .pop_i       (rsp_fire_s),
        .valid_o     (q_valid_s),
        .data_o      (q_data_s)
    );

    assign rsp_valid = q_valid_s;
    assign rsp_data  = q_data_s[QW-1:TAG_WIDTH];
    assign rsp_tag   = q_data_s[TAG_WIDTH-1:0];
    assign oob_count = oob_q;

endmodule

// File: tb/tb_vx_om_mem_responder.sv
// Directed and random bench for vx_om_mem_responder against a queue-based
// transaction model of the memory channel.
module tb_vx_om_mem_responder;

    localparam int          QS    = 4;
    localparam int          LAT   = 2;
    localparam logic [31:0] BASE  = 32'd16;
    localparam logic [31:0] WORDS = 32'd1024;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_rw;
    logic [31:0] req_addr;
    logic [3:0]  req_byteen;
    logic [31:0] req_data;
    logic [7:0]  req_tag;
    logic        req_ready, rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [7:0]  rsp_tag;
    logic [15:0] oob_count;

    always #5 clk = ~clk;

    vx_om_mem_responder #(
        .ADDR_WIDTH(32), .TAG_WIDTH(8), .MEM_WORDS(1024), .BASE_ADDR(BASE),
        .LATENCY(LAT), .RSP_QUEUE_SIZE(QS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_rw(req_rw),
        .req_addr(req_addr), .req_byteen(req_byteen), .req_data(req_data),
        .req_tag(req_tag), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_ready(rsp_ready),
        .oob_count(oob_count)
    );

    typedef struct {
        logic [31:0] data;
        logic [7:0]  tag;
        int          rdy;
    } exp_rsp_t;

    exp_rsp_t    pend[$];
    logic [31:0] mem_m [logic [31:0]];
    logic [31:0] log_data[$];
    logic [7:0]  log_tag[$];
    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    int          oob_m = 0;
    bit          last_rd_acc, last_rsp_fire;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", name, obs, exp, cyc);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        logic [31:0] d;
        d = a - BASE;
        return d < WORDS;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // One clock: check outputs at the falling edge, then advance the model.
    task automatic cycle();
        bit       exp_valid, exp_ready, rd_acc, wr_acc, fire;
        exp_rsp_t e;
        @(negedge clk);
        exp_valid = (pend.size() > 0) && (pend[0].rdy <= cyc);
        exp_ready = req_rw ? 1'b1 : (pend.size() < QS);
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        check("oob_count", 32'(oob_count), 32'(oob_m));
        if (exp_valid) begin
            check("rsp_data", rsp_data, pend[0].data);
            check("rsp_tag", 32'(rsp_tag), 32'(pend[0].tag));
        end
        fire   = exp_valid && rsp_ready;
        rd_acc = req_valid && !req_rw && (pend.size() < QS);
        wr_acc = req_valid && req_rw;
        if (fire) begin
            log_data.push_back(rsp_data);
            log_tag.push_back(rsp_tag);
        end
        @(posedge clk);
        if (fire) void'(pend.pop_front());
        if (rd_acc) begin
            e.data = (in_range(req_addr) && mem_m.exists(req_addr)) ? mem_m[req_addr] : 32'h0;
            e.tag  = req_tag;
            e.rdy  = cyc + LAT;
            pend.push_back(e);
        end
        if (wr_acc && in_range(req_addr))
            mem_m[req_addr] = merge(mem_m.exists(req_addr) ? mem_m[req_addr] : 32'h0, req_data, req_byteen);
        if ((rd_acc || wr_acc) && !in_range(req_addr) && oob_m < 65535) oob_m++;
        last_rd_acc   = rd_acc;
        last_rsp_fire = fire;
        cyc++;
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0; req_rw = 1'b0; req_addr = 32'h0;
        req_byteen = 4'h0; req_data = 32'h0; req_tag = 8'h0;
    endtask

    task automatic drive_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        req_valid = 1'b1; req_rw = 1'b1; req_addr = a; req_data = d; req_byteen = be; req_tag = 8'h0;
    endtask

    task automatic drive_rd(input logic [31:0] a, input logic [7:0] t);
        req_valid = 1'b1; req_rw = 1'b0; req_addr = a; req_tag = t;
        req_data = 32'h0; req_byteen = 4'h0;
    endtask

    task automatic drain(input int budget);
        int n;
        idle();
        rsp_ready = 1'b1;
        n = 0;
        while (pend.size() > 0 && n < budget) begin
            cycle();
            n++;
        end
        check("drain_empty", 32'(pend.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, guard, acc, fires, acc_cyc, rtag;
        logic [31:0] a;
        idle();
        rsp_ready = 1'b0;
        reset_n   = 1'b0;

        // Reset state
        cycle();
        cycle();
        check("reset_rsp_data", rsp_data, 32'h0);
        check("reset_rsp_tag", 32'(rsp_tag), 32'h0);
        reset_n = 1'b1;

        // Initialise a window of words with full writes
        for (int i = 0; i < 32; i++) begin
            drive_wr(BASE + 32'(i), $urandom, 4'hF);
            cycle();
        end

        // Write then read, latency and data
        rsp_ready = 1'b1;
        drive_wr(BASE + 32'd5, 32'hA1B2C3D4, 4'hF); cycle();
        drive_rd(BASE + 32'd5, 8'd3); cycle();
        acc_cyc = cyc - 1;
        idle();
        log_data.delete(); log_tag.delete();
        for (int i = 0; i < 6 && log_data.size() == 0; i++) cycle();
        check("t1_fire_latency", 32'(cyc - 1 - acc_cyc), 32'(LAT));
        check("t1_data", log_data.size() > 0 ? log_data[0] : 32'hx, 32'hA1B2C3D4);
        check("t1_tag", log_tag.size() > 0 ? 32'(log_tag[0]) : 32'hx, 32'd3);

        // Partial byte-enable write
        drive_wr(BASE + 32'd6, 32'h0, 4'hF); cycle();
        drive_wr(BASE + 32'd6, 32'hFFFFFFFF, 4'b0101); cycle();
        drive_rd(BASE + 32'd6, 8'd7); cycle();
        log_data.delete(); log_tag.delete();
        drain(10);
        check("t2_data", log_data.size() > 0 ? log_data[0] : 32'hx, 32'h00FF00FF);

        // Credit exhaustion with a stalled consumer, then ordered drain
        rsp_ready = 1'b0;
        log_data.delete(); log_tag.delete();
        t = 0; guard = 0;
        while (t < 6 && guard < 12) begin
            drive_rd(BASE + 32'(t), 8'(t)); cycle();
            if (last_rd_acc) t++;
            guard++;
        end
        check("t3_accepted_while_stalled", 32'(t), 32'd4);
        rsp_ready = 1'b1;
        guard = 0;
        while (t < 6 && guard < 20) begin
            drive_rd(BASE + 32'(t), 8'(t)); cycle();
            if (last_rd_acc) t++;
            guard++;
        end
        drain(20);
        check("t3_rsp_count", 32'(log_tag.size()), 32'd6);
        for (int i = 0; i < log_tag.size(); i++) check("t3_order", 32'(log_tag[i]), 32'(i));

        // Out-of-range accesses
        log_data.delete(); log_tag.delete();
        drive_wr(BASE, 32'h5555AAAA, 4'hF); cycle();
        drive_rd(32'd8, 8'd9); cycle();
        drive_wr(BASE + 32'd1024, 32'hDEADBEEF, 4'hF); cycle();
        drive_rd(BASE, 8'd10); cycle();
        drain(10);
        check("t4_oob_count", 32'(oob_count), 32'd2);
        check("t4_oob_read", log_data.size() > 1 ? log_data[0] : 32'hx, 32'h0);
        check("t4_oob_tag", log_tag.size() > 1 ? 32'(log_tag[0]) : 32'hx, 32'd9);
        check("t4_no_alias", log_data.size() > 1 ? log_data[1] : 32'hx, 32'h5555AAAA);

        // Full queue with simultaneous pop and accept
        rsp_ready = 1'b0;
        t = 0; guard = 0;
        while (t < 4 && guard < 10) begin
            drive_rd(BASE + 32'(t), 8'(t)); cycle();
            if (last_rd_acc) t++;
            guard++;
        end
        idle();
        for (int i = 0; i < 3; i++) cycle();
        rsp_ready = 1'b1;
        acc = 0; fires = 0; rtag = 32;
        for (int i = 0; i < 12; i++) begin
            drive_rd(BASE + 32'(i % 32), 8'(rtag)); cycle();
            if (last_rd_acc) begin acc++; rtag++; end
            if (last_rsp_fire) fires++;
        end
        check("t5_rsp_per_cycle", 32'(fires), 32'd12);
        check("t5_accepts", 32'(acc), 32'd11);
        drain(20);

        // Reset with reads in flight
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_rd(BASE + 32'(i), 8'(40 + i)); cycle();
        end
        idle();
        #2;
        reset_n = 1'b0;
        pend.delete();
        oob_m = 0;
        #1;
        check("t6_async_rsp_valid", 32'(rsp_valid), 32'd0);
        cycle();
        cycle();
        reset_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        rsp_ready = 1'b0;
        t = 0;
        for (int i = 0; i < 5; i++) begin
            drive_rd(BASE + 32'(i), 8'(50 + i)); cycle();
            if (last_rd_acc) t++;
        end
        check("t6_credits_after_reset", 32'(t), 32'(QS));
        drain(20);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                case ($urandom_range(0, 19))
                    0:       a = 32'd8 + 32'($urandom_range(0, 7));
                    1:       a = BASE + WORDS + 32'($urandom_range(0, 7));
                    2:       a = 32'hFFFF_FFF0;
                    default: a = BASE + 32'($urandom_range(0, 31));
                endcase
                if ($urandom_range(0, 9) < 4) drive_wr(a, $urandom, 4'($urandom_range(0, 15)));
                else drive_rd(a, 8'($urandom_range(0, 255)));
            end else begin
                idle();
            end
            rsp_ready = ($urandom_range(0, 9) < 6);
            cycle();
        end
        drain(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
